mult3_iter: RTL and testbench

MULT3_ITER -- requirements
Module: mult3_iter

---
 rtl/mult3_iter_if.sv | 25 ++
 rtl/mult3_iter.sv | 125 ++++++++++++
 tb/tb_mult3_iter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mult3_iter_if.sv
// Operand/result handshake bundle for mult3_iter.
// The master drives operands and out_ready; the slave returns in_ready, out_valid and prod.
interface mult3_iter_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     c;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [3*WIDTH-1:0]   prod;

  modport master (
    output in_valid, a, b, c, is_signed, out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, a, b, c, is_signed, out_ready,
    output in_ready, out_valid, prod
  );
endinterface

// File: rtl/mult3_iter.sv
// Iterative three-operand multiplier: sign-magnitude shift-add, one multiplier bit per cycle.
// Two passes of WIDTH cycles each (|a|*|b|, then *|c|), result held until out_ready.
module mult3_iter #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mult3_iter_if.slave bus
);
  localparam int PW = 3 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_mb;
  logic [WIDTH-1:0]  r_mc;
  logic [PW-1:0]     r_sh;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_prod;
  logic              r_sign;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_last;
  logic              w_bit;
  logic              w_zero;
  logic              w_sign;
  logic [WIDTH-1:0]  w_ma;
  logic [WIDTH-1:0]  w_mb;
  logic [WIDTH-1:0]  w_mc;
  logic [PW-1:0]     w_sum;

  // Magnitudes; negating the signed minimum wraps to 2^(WIDTH-1), which is exact unsigned.
  assign w_ma = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_mb = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign w_mc = (bus.is_signed && bus.c[WIDTH-1]) ? -bus.c : bus.c;
  assign w_zero = (bus.a == '0) || (bus.b == '0) || (bus.c == '0);
  assign w_sign = bus.is_signed && !w_zero &&
                  (bus.a[WIDTH-1] ^ bus.b[WIDTH-1] ^ bus.c[WIDTH-1]);

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_bit    = (r_state == MUL1) ? r_mb[0] : r_mc[0];
  assign w_sum    = r_acc + (w_bit ? r_sh : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_next = MUL1;
      MUL1:    if (w_last)        w_next = MUL2;
      MUL2:    if (w_last)        w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == IDLE);
    w_out_valid = (r_state == DONE);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.prod      = r_prod;

  // r_sh carries the shifted multiplicand; on the last MUL1 cycle it is reloaded
  // with the finished |a|*|b| so MUL2 reuses the same adder.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_mb   <= '0;
      r_mc   <= '0;
      r_sh   <= '0;
      r_acc  <= '0;
      r_prod <= '0;
      r_sign <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sh   <= PW'(w_ma);
            r_mb   <= w_mb;
            r_mc   <= w_mc;
            r_sign <= w_sign;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        MUL1: begin
          r_mb <= r_mb >> 1;
          if (w_last) begin
            r_sh  <= w_sum;
            r_acc <= '0;
            r_cnt <= '0;
          end else begin
            r_acc <= w_sum;
            r_sh  <= r_sh << 1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        MUL2: begin
          r_mc  <= r_mc >> 1;
          r_acc <= w_sum;
          if (w_last) begin
            r_prod <= r_sign ? -w_sum : w_sum;
            r_cnt  <= '0;
          end else begin
            r_sh  <= r_sh << 1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult3_iter.sv
// Randomized bench for mult3_iter against a cycle-count/arithmetic reference model,
// with literal expectations for the documented corner products.
module tb_mult3_iter;
  localparam int W  = 8;
  localparam int PW = 3 * W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult3_iter_if #(.WIDTH(W)) bus ();
  mult3_iter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;
  bit started     = 1'b0;

  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] z, input logic s);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y)) * longint'($signed(z));
    else   p = longint'(x) * longint'(y) * longint'(z);
    return p[PW-1:0];
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction takes 2*W edges after acceptance, then waits for out_ready.
  int            m_left = 0;
  bit            m_done = 1'b0;
  logic [PW-1:0] m_prod = '0;
  logic [PW-1:0] m_pend = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      if (bus.out_ready) m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_prod = m_pend;
      end
    end else if (bus.in_valid) begin
      m_left = 2 * W;
      m_pend = ref_prod(bus.a, bus.b, bus.c, bus.is_signed);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", PW'(bus.in_ready), PW'(!m_done && m_left == 0));
      check("out_valid", PW'(bus.out_valid), PW'(m_done));
      if (m_done) check("prod", bus.prod, m_prod);
    end
  end

  task automatic scramble();
    bus.a         = W'($urandom);
    bus.b         = W'($urandom);
    bus.c         = W'($urandom);
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc,
                     input logic ts, input int hold, input bit lit_en, input logic [PW-1:0] lit);
    int n;
    bus.a = ta; bus.b = tb_; bus.c = tc; bus.is_signed = ts;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    n = 0;
    while (n < 4 * W) begin
      scramble();
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
      if (bus.out_valid) break;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("latency", PW'(n), PW'(2 * W));
    if (lit_en) check("prod_literal", bus.prod, lit);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      scramble();
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("retire_in_ready", PW'(bus.in_ready), PW'(1));
    check("retire_out_valid", PW'(bus.out_valid), PW'(0));
  endtask

  task automatic abort_at(input int d);
    scramble();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < d; i++) begin
      scramble();
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check("abort_in_ready", PW'(bus.in_ready), PW'(1));
    check("abort_out_valid", PW'(bus.out_valid), PW'(0));
    repeat (2 * W + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    started      = 1'b1;
    check("reset_in_ready", PW'(bus.in_ready), PW'(1));
    check("reset_out_valid", PW'(bus.out_valid), PW'(0));
    check("reset_prod", bus.prod, '0);
    check("model_pin_signed", ref_prod(8'hFD, 8'h05, 8'h07, 1'b1), 24'hFFFF97);
    check("model_pin_umax", ref_prod(8'hFF, 8'hFF, 8'hFF, 1'b0), 24'hFD02FF);

    run(8'd3,   8'd5,   8'd7,   1'b0, 0, 1'b1, 24'h000069);
    run(8'hFF,  8'hFF,  8'hFF,  1'b0, 0, 1'b1, 24'hFD02FF);
    run(8'h80,  8'h80,  8'h80,  1'b1, 0, 1'b1, 24'hE00000);
    run(8'hFD,  8'h05,  8'h07,  1'b1, 0, 1'b1, 24'hFFFF97);
    run(8'hFF,  8'h00,  8'h80,  1'b1, 0, 1'b1, 24'h000000);
    run(8'h81,  8'h7F,  8'h02,  1'b1, 10, 1'b1, 24'hFF81FE);

    abort_at(11);
    run(8'd2, 8'd2, 8'd2, 1'b0, 0, 1'b1, 24'h000008);

    for (int t = 0; t < 150; t++) begin
      logic [W-1:0] ra, rb, rc;
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       ra = '0;
          1:       rb = '0;
          default: rc = '0;
        endcase
      end
      if (t % 25 == 24) abort_at($urandom_range(1, 2 * W + 2));
      run(ra, rb, rc, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, '0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
